// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, sequencer state encoding and the per-cycle
// pipeline control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexBubble;
  } seq_ctl_t;

  // Instructions whose rt field is a source operand (R-type, branches, store).
  function automatic logic usesRt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

  function automatic logic isJump(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      count <= '0;
    else if (clear)                  count <= '0;
    else if (inc && (count != '1))   count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Per-cycle PC / IF-ID / ID-EX control for the five-stage pipeline: load-use
// stalls, jump and branch redirects, and the drain after the halt instruction.
module pipeline_sequencer
  import mips_pkg::*;
#(
  parameter int LOAD_STALL   = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic             done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int CNT_MAX = (LOAD_STALL > DRAIN_CYCLES) ? LOAD_STALL : DRAIN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STALL_LOAD = CW'(LOAD_STALL - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  seq_state_t    state, stateNxt;
  logic [CW-1:0] cnt, cntNxt;
  seq_ctl_t      ctl;
  logic          loadUse;
  logic          stallInc;

  assign loadUse = ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (usesRt(id_opcode) && (ex_rt == id_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      cnt    <= '0;
      halted <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= stateNxt;
      cnt    <= cntNxt;
      halted <= (stateNxt == DRAIN) || (stateNxt == DONE);
      done   <= (stateNxt == DONE);
    end
  end

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    ctl      = '0;
    case (state)
      RUN: begin
        // A taken branch squashes whatever sits in ID, hazard or halt included.
        if (ex_branch_taken) begin
          ctl.pcWrite    = 1'b1;
          ctl.ifidFlush  = 1'b1;
          ctl.idexBubble = 1'b1;
        end else if (loadUse) begin
          ctl.idexBubble = 1'b1;
          if (LOAD_STALL > 1) begin
            stateNxt = STALL;
            cntNxt   = STALL_LOAD;
          end
        end else if (isJump(id_opcode)) begin
          ctl.pcWrite   = 1'b1;
          ctl.ifidFlush = 1'b1;
        end else if (id_opcode == OP_HALT) begin
          stateNxt = DRAIN;
          cntNxt   = DRAIN_LOAD;
        end else begin
          ctl.pcWrite   = 1'b1;
          ctl.ifidWrite = 1'b1;
        end
      end
      // EX holds a bubble during the stall, so no branch can resolve there.
      STALL: begin
        ctl.idexBubble = 1'b1;
        cntNxt         = cnt - CNT_ONE;
        if (cnt == CNT_ONE) stateNxt = RUN;
      end
      DRAIN: begin
        ctl.idexBubble = 1'b1;
        cntNxt         = cnt - CNT_ONE;
        if (cnt == CNT_ONE) stateNxt = DONE;
      end
      DONE: begin
        ctl.idexBubble = 1'b1;
      end
      default: begin
        stateNxt = RUN;
        cntNxt   = '0;
      end
    endcase
  end

  // Reset holds the pipeline frozen with a bubble in ID/EX.
  assign pc_write    = rst_n & ctl.pcWrite;
  assign ifid_write  = rst_n & ctl.ifidWrite;
  assign ifid_flush  = rst_n & ctl.ifidFlush;
  assign idex_bubble = ~rst_n | ctl.idexBubble;

  assign stallInc = rst_n && ((state == RUN) || (state == STALL)) && !ctl.pcWrite;

  sat_counter #(.WIDTH(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stallInc),
    .clear (1'b0),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ifid_flush),
    .clear (1'b0),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Two sequencers (LOAD_STALL=1 / 32-bit counters, LOAD_STALL=3 / 3-bit counters)
// driven by shared inputs and compared each cycle to a behavioural model.
module tb_pipeline_sequencer;

  localparam int DRAIN = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_mem_read, ex_branch_taken;

  logic        pcW [2];
  logic        ifW [2];
  logic        flW [2];
  logic        bub [2];
  logic        hlt [2];
  logic        dn  [2];
  logic [31:0] stA, flA;
  logic [2:0]  stB, flB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_sequencer #(.LOAD_STALL(1), .DRAIN_CYCLES(DRAIN), .CNT_W(32)) dutA (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_write(pcW[0]), .ifid_write(ifW[0]), .ifid_flush(flW[0]), .idex_bubble(bub[0]),
    .halted(hlt[0]), .done(dn[0]), .stall_cycles(stA), .flush_count(flA)
  );

  pipeline_sequencer #(.LOAD_STALL(3), .DRAIN_CYCLES(DRAIN), .CNT_W(3)) dutB (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_write(pcW[1]), .ifid_write(ifW[1]), .ifid_flush(flW[1]), .idex_bubble(bub[1]),
    .halted(hlt[1]), .done(dn[1]), .stall_cycles(stB), .flush_count(flB)
  );

  // Model: hold = frozen cycles still owed to a load-use hazard,
  // age = cycles since the halt was accepted (0 = none yet).
  int     ls   [2] = '{1, 3};
  longint cmax [2] = '{64'hFFFF_FFFF, 7};
  int     hold [2], age [2], nHold [2], nAge [2];
  longint stl  [2], fls [2], nStl [2], nFls [2];
  bit     ePc  [2], eIw [2], eFl [2], eBub [2];
  int     cyc = 0;

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      hold[i] = 0; age[i] = 0; stl[i] = 0; fls[i] = 0;
    end
  endtask

  task automatic modelEval(input int i);
    bit ur, lu, jmp, hl;
    ur  = (id_opcode == 6'd0) || (id_opcode == 6'd4) || (id_opcode == 6'd5) || (id_opcode == 6'd43);
    lu  = ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (ur && (ex_rt == id_rt)));
    jmp = (id_opcode == 6'd2) || (id_opcode == 6'd3);
    hl  = (id_opcode == 6'd63);
    nHold[i] = hold[i];
    nAge[i]  = (age[i] > 0) ? ((age[i] < 99) ? age[i] + 1 : 99) : 0;
    nStl[i]  = stl[i];
    nFls[i]  = fls[i];
    ePc[i] = 0; eIw[i] = 0; eFl[i] = 0; eBub[i] = 0;
    if (!rst_n) eBub[i] = 1;
    else if (age[i] > 0) eBub[i] = 1;
    else if (hold[i] > 0) begin
      eBub[i] = 1; nHold[i] = hold[i] - 1; nStl[i]++;
    end else if (ex_branch_taken) begin
      ePc[i] = 1; eFl[i] = 1; eBub[i] = 1; nFls[i]++;
    end else if (lu) begin
      eBub[i] = 1; nStl[i]++; nHold[i] = ls[i] - 1;
    end else if (jmp) begin
      ePc[i] = 1; eFl[i] = 1; nFls[i]++;
    end else if (hl) begin
      nStl[i]++; nAge[i] = 1;
    end else begin
      ePc[i] = 1; eIw[i] = 1;
    end
    if (nStl[i] > cmax[i]) nStl[i] = cmax[i];
    if (nFls[i] > cmax[i]) nFls[i] = cmax[i];
  endtask

  task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] cycle=%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < 2; i++) begin
      chk("pc_write",    i, {63'd0, pcW[i]}, {63'd0, ePc[i]});
      chk("ifid_write",  i, {63'd0, ifW[i]}, {63'd0, eIw[i]});
      chk("ifid_flush",  i, {63'd0, flW[i]}, {63'd0, eFl[i]});
      chk("idex_bubble", i, {63'd0, bub[i]}, {63'd0, eBub[i]});
      chk("halted",      i, {63'd0, hlt[i]}, {63'd0, age[i] >= 1});
      chk("done",        i, {63'd0, dn[i]},  {63'd0, age[i] >= DRAIN + 1});
      chk("stall_cycles", i, (i == 0) ? {32'd0, stA} : {61'd0, stB}, stl[i]);
      chk("flush_count",  i, (i == 0) ? {32'd0, flA} : {61'd0, flB}, fls[i]);
    end
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model on the edge.
  task automatic step(input bit r, input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt,
                      input bit mr, input bit [4:0] ert, input bit bt);
    rst_n = r; id_opcode = op; id_rs = rs; id_rt = rt;
    ex_mem_read = mr; ex_rt = ert; ex_branch_taken = bt;
    #1;
    if (!r) modelReset();
    modelEval(0);
    modelEval(1);
    @(negedge clk);
    checkAll();
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        hold[i] = nHold[i]; age[i] = nAge[i]; stl[i] = nStl[i]; fls[i] = nFls[i];
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 6'd35, 5'd1, 5'd2, 0, 5'd0, 0);
  endtask

  task automatic randSteps(input int n, input int haltOdds, input int rstOdds);
    bit [5:0] ops [8] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd35, 6'd43, 6'd8};
    bit [5:0] op;
    for (int k = 0; k < n; k++) begin
      op = ops[$urandom_range(7)];
      if ($urandom_range(haltOdds) == 0) op = 6'd63;
      step(($urandom_range(rstOdds) != 0), op, 5'($urandom_range(4)), 5'($urandom_range(4)),
           ($urandom_range(2) == 0), 5'($urandom_range(4)), ($urandom_range(9) == 0));
    end
  endtask

  initial begin
    modelReset();
    // Reset state and forced outputs
    step(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0);
    step(0, 6'd2, 5'd8, 5'd8, 1, 5'd8, 1);
    idle(2);
    // Load-use on rs=8
    step(1, 6'd35, 5'd8, 5'd9, 1, 5'd8, 0);
    idle(4);
    // Load-use on rt for an rt-reading opcode, and on rt for a load (no hazard)
    step(1, 6'd0, 5'd3, 5'd7, 1, 5'd7, 0);
    idle(3);
    step(1, 6'd35, 5'd3, 5'd7, 1, 5'd7, 0);
    // ex_rt = 0 never stalls
    step(1, 6'd0, 5'd0, 5'd0, 1, 5'd0, 0);
    idle(1);
    // Jump
    step(1, 6'd2, 5'd1, 5'd2, 0, 5'd0, 0);
    step(1, 6'd3, 5'd1, 5'd2, 0, 5'd0, 0);
    idle(1);
    // Branch + load-use + halt together: branch wins, no halt
    step(1, 6'd63, 5'd8, 5'd8, 1, 5'd8, 1);
    idle(3);
    // Load-use with a jump in ID: stall first, jump afterwards
    step(1, 6'd2, 5'd5, 5'd0, 1, 5'd5, 0);
    for (int k = 0; k < 3; k++) step(1, 6'd2, 5'd5, 5'd0, 0, 5'd0, 0);
    idle(1);
    // Random flow without halts
    randSteps(300, 1000000, 1000000);
    // Halt at cycle 10 after reset, then 20 frozen cycles
    step(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(9);
    step(1, 6'd63, 5'd0, 5'd0, 0, 5'd0, 0);
    randSteps(20, 1000000, 1000000);
    // Reset pulse mid-drain, then normal fetch
    step(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(2);
    step(1, 6'd63, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(2);
    step(0, 6'd35, 5'd0, 5'd0, 0, 5'd0, 0);
    idle(3);
    // Random flow with halts and resets
    randSteps(600, 40, 50);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Cycle-level sequencer for the five-stage MIPS pipeline: decides every cycle whether the PC and the IF/ID register advance, hold or flush, and whether a bubble is injected into ID/EX. It detects load-use hazards and holds the pipeline for a configurable number of cycles. It redirects on jumps (resolved in ID) and taken branches (resolved in EX). It drains the pipeline after the all-ones terminating instruction and raises a sticky `done`. It sits beside the instruction decoder; its `idex_bubble` drives the decoder-side hazard MSB of the ALU-source select and forces ID/EX control to zero.

## Interface
- `LOAD_STALL`, 1: cycles the pipeline holds on a load-use hazard; minimum 1.
- `DRAIN_CYCLES`, 3: cycles spent draining EX/MEM/WB after the halt leaves ID; minimum 1.
- `CNT_W`, 32: width of the performance counters.

- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_opcode`  in  6  opcode of the instruction in ID.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_rt`  in  5  destination register of the instruction in EX.
- `ex_branch_taken`  in  1  branch in EX resolved taken this cycle.
- `pc_write`  out  1  PC loads its next value.
- `ifid_write`  out  1  IF/ID captures the fetched instruction.
- `ifid_flush`  out  1  IF/ID loads a NOP.
- `idex_bubble`  out  1  ID/EX loads all-zero control.
- `halted`  out  1  fetch is frozen: state is DRAIN or DONE.
- `done`  out  1  pipeline empty after halt; sticky until reset.
- `stall_cycles`  out  CNT_W  saturating count of hazard-hold cycles.
- `flush_count`  out  CNT_W  saturating count of cycles with `ifid_flush`=1.

## Operation
- States: RUN, STALL, DRAIN, DONE. A down-counter `cnt` is shared by STALL and DRAIN.
- The outputs `pc_write`, `ifid_write`, `ifid_flush` and `idex_bubble` are Mealy outputs of state and the current inputs.
- `id_uses_rt` is 1 for the opcodes 000000, 000100, 000101 and 101011.
- `load_use` = `ex_mem_read` & (`ex_rt`≠0) & ((`ex_rt`==`id_rs`) | (`id_uses_rt` & `ex_rt`==`id_rt`)).
- Halt is recognised when `id_opcode`==6'b111111.
- RUN applies the first matching case in this priority order:
  1. `ex_branch_taken`: `pc_write`=1, `ifid_flush`=1, `idex_bubble`=1. Stay in RUN. This also discards any hazard, jump or halt in ID.
  2. `load_use`: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1. If `LOAD_STALL`>1, go to STALL with `cnt`=`LOAD_STALL`-1.
  3. Jump (opcode 000010 or 000011): `pc_write`=1, `ifid_flush`=1.
  4. Halt: `pc_write`=0, `ifid_write`=0. Go to DRAIN with `cnt`=`DRAIN_CYCLES`.
  5. Otherwise: `pc_write`=1, `ifid_write`=1, flush and bubble 0.
- STALL:
  - Outputs: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
  - `cnt` decrements each cycle; return to RUN when `cnt`==1.
  - `ex_branch_taken` is ignored here, because EX holds a bubble.
- DRAIN:
  - Outputs: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
  - `cnt` decrements each cycle; go to DONE when `cnt`==1.
- DONE: same outputs as DRAIN; `done`=1; the only exit is reset.
- Counters:
  - `stall_cycles` increments on each cycle in RUN or STALL with `pc_write`=0.
  - `flush_count` increments on each cycle with `ifid_flush`=1.
  - Both hold at all-ones.

## Timing
- Reset (asynchronous, `rst_n` low): state=RUN, `cnt`=0, counters=0, `done`=0, `halted`=0.
- While `rst_n` is low the outputs are forced to `pc_write`=0, `ifid_write`=0, `ifid_flush`=0, `idex_bubble`=1.
- Reset asserted mid-STALL or mid-DRAIN aborts the sequence immediately.
- Decisions are zero-latency: hazard, jump and branch outputs respond in the same cycle as their inputs.
- A load-use hazard freezes the PC for exactly `LOAD_STALL` consecutive cycles.
- A halt in ID at cycle t gives:
  - `halted`=1 from cycle t+1.
  - `done`=1 from cycle t+`DRAIN_CYCLES`+1.
- `done` and `halted` are registered outputs.
- A branch taken together with a halt in ID means the halt is flushed and not acted on.
- A load-use hazard together with a jump in ID: the stall wins; the jump is taken on the first RUN cycle after the stall.

## Structure
- A shared package `mips_pkg` holds:
  - the opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_HALT);
  - the state enum `seq_state_t`.
- Sub-module `sat_counter` (parameter width, inputs `inc` and clear) is instantiated twice for the performance counters.

## Test plan
- `ex_mem_read`=1, `ex_rt`=8, `id_rs`=8, `LOAD_STALL`=1 → one cycle with `pc_write`=0 and `idex_bubble`=1, then normal flow; `stall_cycles`=1.
- Same hazard with `LOAD_STALL`=3 → `pc_write`=0 for exactly 3 cycles; a hazard on `ex_rt`=0 causes no stall.
- `id_opcode`=000010 → `ifid_flush`=1 for one cycle with `pc_write`=1; `flush_count`=1.
- `ex_branch_taken`=1 in the same cycle as `load_use`=1 and halt in ID → flush and bubble asserted, no stall, `halted` stays 0.
- Halt in ID at cycle 10, `DRAIN_CYCLES`=3 → `halted` from cycle 11, `done` from cycle 14; `pc_write` stays 0 through 20 cycles.
- `rst_n` pulsed low during DRAIN → state RUN, `done`=0, counters 0; normal fetch resumes on the first edge after release.
